// File: rtl/core_axi4l_master.sv
// core_axi4l_master
// Bridges the core LSU load/store request/response port to an AXI4-Lite
// master. Only one transaction is in flight at a time. The bridge steers
// store data onto byte lanes, generates write strobes, and extracts and
// extends load data. It also rejects misaligned or illegal-size requests
// without starting any AXI traffic.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_*               core request (valid/ready, we, addr, wdata, size, signed)
//   rsp_*               core response (valid/ready, rdata, err)
//   m_axi_aw*/w*/b*     AXI4-Lite write address / data / response channels
//   m_axi_ar*/r*        AXI4-Lite read address / data channels
module core_axi4l_master #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_size;
  logic                r_signed;
  logic [DATA_W-1:0]   r_wdata;
  logic [3:0]          r_wstrb;
  logic                r_aw_done;
  logic                r_w_done;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;

  logic                w_accept;
  logic                w_misalign;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic [DATA_W-1:0]   w_lane_wdata;
  logic [3:0]          w_lane_wstrb;
  logic [7:0]          w_rd_byte;
  logic [15:0]         w_rd_half;
  logic [DATA_W-1:0]   w_rd_ext;
  logic                w_unused;

  // Only bit 1 of the response codes matters: SLVERR and DECERR both set it.
  assign w_unused = &{1'b0, m_axi_bresp[0], m_axi_rresp[0]};

  assign w_accept   = req_valid && (r_state == IDLE);
  assign w_misalign = (req_size == 2'b11)
                   || ((req_size == 2'b01) && req_addr[0])
                   || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign w_aw_hs    = m_axi_awvalid && m_axi_awready;
  assign w_w_hs     = m_axi_wvalid && m_axi_wready;

  // Store data is replicated across all lanes, so the strobe alone selects
  // the bytes that are written.
  always_comb begin
    w_lane_wdata = req_wdata;
    w_lane_wstrb = 4'b0000;
    case (req_size)
      2'b00: begin
        w_lane_wdata = {4{req_wdata[7:0]}};
        w_lane_wstrb = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        w_lane_wdata = {2{req_wdata[15:0]}};
        w_lane_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: w_lane_wstrb = 4'b1111;
      default: ;
    endcase
  end

  always_comb begin
    w_rd_byte = '0;
    case (r_addr[1:0])
      2'd0: w_rd_byte = m_axi_rdata[7:0];
      2'd1: w_rd_byte = m_axi_rdata[15:8];
      2'd2: w_rd_byte = m_axi_rdata[23:16];
      2'd3: w_rd_byte = m_axi_rdata[31:24];
      default: ;
    endcase
    w_rd_half = r_addr[1] ? m_axi_rdata[31:16] : m_axi_rdata[15:0];
    case (r_size)
      2'b00:   w_rd_ext = {{24{r_signed & w_rd_byte[7]}}, w_rd_byte};
      2'b01:   w_rd_ext = {{16{r_signed & w_rd_half[15]}}, w_rd_half};
      default: w_rd_ext = m_axi_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    req_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    rsp_valid     = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (w_accept) begin
          if (w_misalign)  w_next = RSP;
          else if (req_we) w_next = WR_REQ;
          else             w_next = RD_REQ;
        end
      end
      WR_REQ: begin
        // AW and W complete independently; leave once both have completed,
        // counting a handshake that happens in this same cycle.
        m_axi_awvalid = !r_aw_done;
        m_axi_wvalid  = !r_w_done;
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = WR_RESP;
      end
      WR_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) w_next = RSP;
      end
      RD_REQ: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) w_next = RD_RESP;
      end
      RD_RESP: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) w_next = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_size    <= '0;
      r_signed  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_addr    <= req_addr;
          r_size    <= req_size;
          r_signed  <= req_signed;
          r_wdata   <= w_lane_wdata;
          r_wstrb   <= w_lane_wstrb;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          r_rdata   <= '0;
          r_err     <= w_misalign;
        end
        WR_REQ: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
        end
        WR_RESP: if (m_axi_bvalid) r_err <= m_axi_bresp[1];
        RD_RESP: if (m_axi_rvalid) begin
          r_rdata <= w_rd_ext;
          r_err   <= m_axi_rresp[1];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    m_axi_awaddr = r_addr;
    m_axi_araddr = r_addr;
    m_axi_awprot = 3'b000;
    m_axi_arprot = 3'b000;
    m_axi_wdata  = r_wdata;
    m_axi_wstrb  = r_wstrb;
    rsp_rdata    = r_rdata;
    rsp_err      = r_err;
  end

endmodule

// File: tb/tb_core_axi4l_master.sv
module tb_core_axi4l_master;

  localparam int unsigned ADDR_W = 32;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [1:0]        req_size;
  logic              req_signed;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] m_axi_awaddr;
  logic [2:0]        m_axi_awprot;
  logic              m_axi_awvalid;
  logic              m_axi_awready;
  logic [31:0]       m_axi_wdata;
  logic [3:0]        m_axi_wstrb;
  logic              m_axi_wvalid;
  logic              m_axi_wready;
  logic [1:0]        m_axi_bresp;
  logic              m_axi_bvalid;
  logic              m_axi_bready;
  logic [ADDR_W-1:0] m_axi_araddr;
  logic [2:0]        m_axi_arprot;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [31:0]       m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rvalid;
  logic              m_axi_rready;

  core_axi4l_master #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_signed(req_signed),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Slave model: word memory, configurable ready delays and response code.
  int unsigned cfg_aw_delay = 0;
  int unsigned cfg_w_delay  = 0;
  int unsigned cfg_ar_delay = 0;
  logic [1:0]  cfg_resp     = 2'b00;
  logic [31:0] mem [0:255];

  initial begin : slave
    logic        aw_got, w_got;
    logic [31:0] aw_a, ar_a, w_d;
    logic [3:0]  w_s;
    int unsigned aw_cnt, w_cnt, ar_cnt;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    aw_got = 0; w_got = 0; aw_a = '0; ar_a = '0; w_d = '0; w_s = '0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0;
    m_axi_rresp = 0; m_axi_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_rvalid = 0;
      end else begin
        // A ready/valid raised at the previous negedge completed at the edge
        // in between, because the master holds its side until handshake.
        if (m_axi_bvalid) m_axi_bvalid = 0;
        if (m_axi_rvalid) m_axi_rvalid = 0;
        if (m_axi_awready) begin m_axi_awready = 0; aw_got = 1; end
        if (m_axi_wready)  begin m_axi_wready  = 0; w_got  = 1; end
        if (m_axi_arready) begin
          m_axi_arready = 0;
          m_axi_rvalid  = 1;
          m_axi_rdata   = mem[ar_a[9:2]];
          m_axi_rresp   = cfg_resp;
        end
        if (aw_got && w_got) begin
          for (int b = 0; b < 4; b++)
            if (w_s[b]) mem[aw_a[9:2]][b*8 +: 8] = w_d[b*8 +: 8];
          m_axi_bvalid = 1;
          m_axi_bresp  = cfg_resp;
          aw_got = 0; w_got = 0;
        end
        if (m_axi_awvalid && !aw_got) begin
          if (aw_cnt >= cfg_aw_delay) begin
            m_axi_awready = 1; aw_a = m_axi_awaddr; aw_cnt = 0;
          end else aw_cnt++;
        end
        if (m_axi_wvalid && !w_got) begin
          if (w_cnt >= cfg_w_delay) begin
            m_axi_wready = 1; w_d = m_axi_wdata; w_s = m_axi_wstrb; w_cnt = 0;
          end else w_cnt++;
        end
        if (m_axi_arvalid) begin
          if (ar_cnt >= cfg_ar_delay) begin
            m_axi_arready = 1; ar_a = m_axi_araddr; ar_cnt = 0;
          end else ar_cnt++;
        end
      end
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  resp;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_axi;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    int unsigned exp_lat;
  } vec_t;

  function automatic vec_t V(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [1:0] size, input logic sgn, input logic [1:0] resp,
                             input logic [31:0] er, input logic ee, input logic ea,
                             input logic [31:0] ewd, input logic [3:0] ews, input int unsigned lat);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.size = size; v.sgn = sgn; v.resp = resp;
    v.exp_rdata = er; v.exp_err = ee; v.exp_axi = ea; v.exp_wdata = ewd;
    v.exp_wstrb = ews; v.exp_lat = lat;
    return v;
  endfunction

  // One request/response through a well-behaved core; samples at negedges.
  // Cycle k = 1 is the cycle right after the accepting edge.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic sgn,
                        output logic got, output logic [31:0] rdata, output logic err,
                        output int unsigned lat, output int unsigned first,
                        output logic aw_seen, output logic w_seen, output logic ar_seen,
                        output logic [31:0] cap_addr, output logic [31:0] cap_wd,
                        output logic [3:0] cap_ws, output logic proto_ok);
    int unsigned k;
    got = 0; rdata = '0; err = 0; lat = 0; first = 0; aw_seen = 0; w_seen = 0;
    ar_seen = 0; cap_addr = '0; cap_wd = '0; cap_ws = '0; proto_ok = 1;
    @(negedge clk);
    check_b("req_ready_before_accept", req_ready, 1'b1);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_size = size; req_signed = sgn;
    @(posedge clk); #1;
    req_valid = 0;
    k = 0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (m_axi_awvalid && !aw_seen) begin
        aw_seen = 1; cap_addr = m_axi_awaddr; if (first == 0) first = k;
      end
      if (m_axi_arvalid && !ar_seen) begin
        ar_seen = 1; cap_addr = m_axi_araddr; if (first == 0) first = k;
      end
      if (m_axi_wvalid) begin w_seen = 1; cap_wd = m_axi_wdata; cap_ws = m_axi_wstrb; end
      if (req_ready) proto_ok = 0;
      if ((m_axi_awvalid || m_axi_wvalid) && m_axi_arvalid) proto_ok = 0;
      if ((m_axi_awvalid && m_axi_awprot != 3'b000) || (m_axi_arvalid && m_axi_arprot != 3'b000))
        proto_ok = 0;
      if (rsp_valid) begin got = 1; rdata = rsp_rdata; err = rsp_err; lat = k; end
    end
    if (got) begin
      rsp_ready = 1;
      @(posedge clk); #1;
      rsp_ready = 0;
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t        vq[$];
    logic        got, err, aw_s, w_s, ar_s, pok;
    logic [31:0] rdata, caddr, cwd;
    logic [3:0]  cws;
    int unsigned lat, first, k;

    rst = 1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    req_size = 0; req_signed = 0; rsp_ready = 0;

    //        we addr          wdata         sz sg rsp exp_rdata     err axi exp_wdata     strb lat
    vq.push_back(V(1, 32'h100, 32'hDEADBEEF, 2, 0, 0, 32'h0,        0, 1, 32'hDEADBEEF, 4'hF, 3));
    vq.push_back(V(0, 32'h100, 32'h0,        2, 0, 0, 32'hDEADBEEF, 0, 1, 32'h0,        4'h0, 3));
    vq.push_back(V(1, 32'h103, 32'h123456A5, 0, 0, 0, 32'h0,        0, 1, 32'hA5A5A5A5, 4'h8, 3));
    vq.push_back(V(0, 32'h103, 32'h0,        0, 1, 0, 32'hFFFFFFA5, 0, 1, 32'h0,        4'h0, 3));
    vq.push_back(V(0, 32'h103, 32'h0,        0, 0, 0, 32'h000000A5, 0, 1, 32'h0,        4'h0, 3));
    vq.push_back(V(1, 32'h100, 32'h80011234, 2, 0, 0, 32'h0,        0, 1, 32'h80011234, 4'hF, 3));
    vq.push_back(V(0, 32'h102, 32'h0,        1, 1, 0, 32'hFFFF8001, 0, 1, 32'h0,        4'h0, 3));
    vq.push_back(V(0, 32'h102, 32'h0,        1, 0, 0, 32'h00008001, 0, 1, 32'h0,        4'h0, 3));
    vq.push_back(V(0, 32'h100, 32'h0,        1, 1, 0, 32'h00001234, 0, 1, 32'h0,        4'h0, 3));
    vq.push_back(V(1, 32'h102, 32'hFFFF7E5A, 1, 0, 0, 32'h0,        0, 1, 32'h7E5A7E5A, 4'hC, 3));
    vq.push_back(V(0, 32'h100, 32'h0,        2, 0, 0, 32'h7E5A1234, 0, 1, 32'h0,        4'h0, 3));
    vq.push_back(V(0, 32'h101, 32'h0,        0, 0, 0, 32'h00000012, 0, 1, 32'h0,        4'h0, 3));
    vq.push_back(V(1, 32'h100, 32'h00000080, 0, 0, 0, 32'h0,        0, 1, 32'h80808080, 4'h1, 3));
    vq.push_back(V(0, 32'h100, 32'h0,        0, 1, 0, 32'hFFFFFF80, 0, 1, 32'h0,        4'h0, 3));
    vq.push_back(V(0, 32'h102, 32'h0,        0, 1, 0, 32'h0000005A, 0, 1, 32'h0,        4'h0, 3));
    vq.push_back(V(0, 32'h101, 32'h0,        2, 0, 0, 32'h0,        1, 0, 32'h0,        4'h0, 1));
    vq.push_back(V(0, 32'h100, 32'h0,        3, 0, 0, 32'h0,        1, 0, 32'h0,        4'h0, 1));
    vq.push_back(V(1, 32'h101, 32'h0000FFFF, 1, 0, 0, 32'h0,        1, 0, 32'h0,        4'h0, 1));
    vq.push_back(V(1, 32'h102, 32'h12345678, 2, 0, 0, 32'h0,        1, 0, 32'h0,        4'h0, 1));
    vq.push_back(V(0, 32'h100, 32'h0,        2, 0, 3, 32'h7E5A1280, 1, 1, 32'h0,        4'h0, 3));
    vq.push_back(V(1, 32'h104, 32'h11223344, 2, 0, 1, 32'h0,        0, 1, 32'h11223344, 4'hF, 3));
    vq.push_back(V(0, 32'h106, 32'h0,        1, 0, 0, 32'h00001122, 0, 1, 32'h0,        4'h0, 3));
    vq.push_back(V(1, 32'h101, 32'h0000003C, 0, 0, 0, 32'h0,        0, 1, 32'h3C3C3C3C, 4'h2, 3));
    vq.push_back(V(0, 32'h100, 32'h0,        2, 0, 0, 32'h7E5A3C80, 0, 1, 32'h0,        4'h0, 3));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_b("reset req_ready", req_ready, 1'b1);
    check_b("reset awvalid", m_axi_awvalid, 1'b0);
    check_b("reset wvalid", m_axi_wvalid, 1'b0);
    check_b("reset arvalid", m_axi_arvalid, 1'b0);
    check_b("reset bready", m_axi_bready, 1'b0);
    check_b("reset rready", m_axi_rready, 1'b0);
    check_b("reset rsp_valid", rsp_valid, 1'b0);
    check_b("reset rsp_err", rsp_err, 1'b0);
    check_w("reset rsp_rdata", rsp_rdata, 32'h0);
    check_w("reset awaddr", m_axi_awaddr, 32'h0);
    @(negedge clk);
    rst = 0;

    foreach (vq[i]) begin
      vec_t v;
      v = vq[i];
      cfg_resp = v.resp;
      do_req(v.we, v.addr, v.wdata, v.size, v.sgn, got, rdata, err, lat, first,
             aw_s, w_s, ar_s, caddr, cwd, cws, pok);
      check_b($sformatf("v%0d rsp_seen", i), got, 1'b1);
      check_w($sformatf("v%0d rdata", i), rdata, v.exp_rdata);
      check_b($sformatf("v%0d err", i), err, v.exp_err);
      check_w($sformatf("v%0d rsp_latency", i), lat, v.exp_lat);
      check_b($sformatf("v%0d aw_seen", i), aw_s, v.exp_axi & v.we);
      check_b($sformatf("v%0d w_seen", i), w_s, v.exp_axi & v.we);
      check_b($sformatf("v%0d ar_seen", i), ar_s, v.exp_axi & ~v.we);
      check_b($sformatf("v%0d protocol", i), pok, 1'b1);
      if (v.exp_axi) begin
        check_w($sformatf("v%0d first_valid_cycle", i), first, 1);
        check_w($sformatf("v%0d axi_addr", i), caddr, v.addr);
        if (v.we) begin
          check_w($sformatf("v%0d wdata", i), cwd, v.exp_wdata);
          check_w($sformatf("v%0d wstrb", i), {28'd0, cws}, {28'd0, v.exp_wstrb});
        end
      end
    end
    cfg_resp = 2'b00;

    // Stalled slave: W completes 3 cycles before AW, SLVERR response,
    // and the core holds off rsp_ready for 4 cycles.
    cfg_aw_delay = 3;
    cfg_resp = 2'b10;
    @(negedge clk);
    req_valid = 1; req_we = 1; req_addr = 32'h200; req_wdata = 32'h55667788;
    req_size = 2; req_signed = 0;
    @(posedge clk); #1;
    req_valid = 0;
    got = 0; k = 0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (rsp_valid) got = 1;
      else begin
        check_b($sformatf("stall awvalid c%0d", k), m_axi_awvalid, k <= 4);
        check_b($sformatf("stall wvalid c%0d", k), m_axi_wvalid, k == 1);
        check_b($sformatf("stall req_ready c%0d", k), req_ready, 1'b0);
      end
    end
    check_w("stall rsp_latency", k, 6);
    for (int c = 0; c < 4; c++) begin
      check_b($sformatf("stall hold rsp_valid c%0d", c), rsp_valid, 1'b1);
      check_b($sformatf("stall hold rsp_err c%0d", c), rsp_err, 1'b1);
      check_w($sformatf("stall hold rsp_rdata c%0d", c), rsp_rdata, 32'h0);
      check_b($sformatf("stall hold req_ready c%0d", c), req_ready, 1'b0);
      @(negedge clk);
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    check_b("stall rsp_valid after ack", rsp_valid, 1'b0);
    check_b("stall req_ready after ack", req_ready, 1'b1);
    cfg_aw_delay = 0;
    cfg_resp = 2'b00;

    // Reset while awvalid is high
    cfg_aw_delay = 20;
    @(negedge clk);
    req_valid = 1; req_we = 1; req_addr = 32'h300; req_wdata = 32'hCAFEF00D;
    req_size = 2; req_signed = 0;
    @(posedge clk); #1;
    req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    check_b("rstmid awvalid before", m_axi_awvalid, 1'b1);
    rst = 1;
    @(posedge clk); #1;
    check_b("rstmid awvalid", m_axi_awvalid, 1'b0);
    check_b("rstmid wvalid", m_axi_wvalid, 1'b0);
    check_b("rstmid rsp_valid", rsp_valid, 1'b0);
    check_b("rstmid req_ready", req_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    cfg_aw_delay = 0;
    do_req(1'b0, 32'h104, 32'h0, 2'd2, 1'b0, got, rdata, err, lat, first,
           aw_s, w_s, ar_s, caddr, cwd, cws, pok);
    check_b("post-reset load rsp_seen", got, 1'b1);
    check_w("post-reset load rdata", rdata, 32'h11223344);
    check_b("post-reset load err", err, 1'b0);
    check_w("post-reset load latency", lat, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/core_axi4l_master.md
Name: core_axi4l_master

Overview:
- Bridges the core's load/store request/response port to an AXI4-Lite master, which feeds the on-chip SRAM slave and other AXI4-Lite peripherals.
- Allows one outstanding transaction.
- Performs byte/half/word lane steering, write-strobe generation, read-data extraction with sign/zero extension, and alignment checking.
- Sits between the core LSU and the AXI4-Lite slaves.

Parameters:
- ADDR_W, 32, address width (matches `MemAddrBus).
- DATA_W, 32, data width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  core request valid.
- req_ready  out  1  bridge can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_signed  in  1  load sign-extends when 1.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  32  extended load data; 0 for stores.
- rsp_err  out  1  misaligned, illegal size, or SLVERR/DECERR.
- m_axi_awaddr/awprot/awvalid/awready  out/out/out/in  ADDR_W/3/1/1  AW channel.
- m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  W channel.
- m_axi_bresp/bvalid/bready  in/in/out  2/1/1  B channel.
- m_axi_araddr/arprot/arvalid/arready  out/out/out/in  ADDR_W/3/1/1  AR channel.
- m_axi_rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  R channel.

Behaviour:
- Single clock clk; rst is synchronous, active-high.
- Reset values: state = IDLE; all *valid, bready, rready, rsp_valid and rsp_err are 0; rsp_rdata = 0; address/data registers = 0.
- Reset mid-transaction drops all valids the next edge; no completion of the in-flight transfer is required.
- awprot = arprot = 3'b000 always. awaddr/araddr carry the full byte address, unmodified.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- req_ready = 1 only in IDLE; a request is accepted on req_valid & req_ready.
- Request accept:
  - Latch addr, we, size, signed, and the lane-shifted wdata: byte replicated to all lanes, half replicated to both halves.
  - Latch wstrb: byte 4'b0001 << addr[1:0]; half 4'b0011 << addr[1]*2; word 4'b1111.
- Alignment check at accept:
  - half with addr[0] = 1, word with addr[1:0] != 0, or size = 11 → go to RSP with rsp_err = 1, rsp_rdata = 0.
  - No AXI activity for these requests.
- Aligned store → WR_REQ; aligned load → RD_REQ.
- WR_REQ:
  - awvalid and wvalid both rise the cycle after accept.
  - Each drops independently after its own handshake; track with aw_done/w_done flags.
  - Valid and payload are held stable until handshake.
  - When both are done (including both in the same cycle) → WR_RESP.
- WR_RESP: bready = 1. On bvalid, capture err = bresp[1] → RSP.
- RD_REQ: arvalid = 1 until arready → RD_RESP.
- RD_RESP: rready = 1. On rvalid:
  - Extract the lane at addr[1:0] (byte) or addr[1] (half).
  - Zero- or sign-extend per signed.
  - err = rresp[1] → RSP.
- RSP:
  - rsp_valid = 1, payload held stable until rsp_ready → IDLE.
  - A new request may be accepted the cycle after the return to IDLE, not in the same cycle (no bypass).
- Latency with a zero-wait slave, accept at cycle T: AXI valid at T+1, b/rvalid at T+2, rsp_valid at T+3.
- Misaligned request: rsp_valid at T+1.
- Only one channel pair is active at a time; reads and writes never overlap.
- No timeout: AXI valids are never withdrawn before their handshake.

Test Plan:
- Word store addr 0x100, data 0xDEADBEEF, zero-wait slave → awvalid/wvalid at T+1, wstrb 4'hF, bready at T+2, rsp_valid at T+3 with err = 0; a subsequent word load of 0x100 returns 0xDEADBEEF.
- Byte store 0xA5 to addr 0x103 → wdata 0xA5A5A5A5, wstrb 4'b1000. Signed byte load 0x103 → 0xFFFFFFA5; unsigned → 0x000000A5.
- Half load addr 0x102 with rdata 0x8001_1234 → signed 0xFFFF8001, unsigned 0x00008001.
- Misaligned word load addr 0x101 → no arvalid, rsp_valid at T+1, rsp_err = 1, rsp_rdata = 0. size = 11 behaves the same.
- Slave stalls: wready arrives 3 cycles before awready, bresp = 2'b10 → wvalid drops after its handshake while awvalid stays high; rsp_err = 1; rsp_valid is held while rsp_ready is low for 4 cycles; req_ready stays 0 throughout.
- rst asserted while awvalid = 1 → the next edge clears awvalid, wvalid and rsp_valid; req_ready = 1; a following load completes normally.
